demux1a2_stripe_l2: RTL
=======================

// Module: demux1a2_stripe_l2
// PURPOSE
//  Upstream striping stage feeding the L1 2-to-4 demux. Takes one byte stream at clk_4f rate.
//  Alternates bytes onto two lanes: even bytes go to lane 0, odd bytes to lane 1.
//  Publishes each aligned lane pair on a half-rate window, so both lane outputs stay stable
//  for 2 clk_4f cycles and can be sampled by the clk_2f stage.
// PARAMETERS
//  DATA_W         8   lane/byte width
//  FLUSH_TIMEOUT  4   idle cycles before a stranded lane-0 byte is flushed (PARTIAL_FLUSH_EN only)
// PORTS
//  clk_4f       in   1       single clock, rising edge; all state lives in this domain
//  reset_L      in   1       asynchronous, active-low reset
//  data_in      in   DATA_W  input byte
//  valid_in     in   1       data_in is valid this cycle; no backpressure
//  data_out0    out  DATA_W  lane 0 byte (even stream index)
//  data_out1    out  DATA_W  lane 1 byte (odd stream index)
//  valid_out0   out  1       data_out0 holds a new byte for this window
//  valid_out1   out  1       data_out1 holds a new byte for this window
//  phase_2f     out  1       window phase: 0,1,0,1...; outputs update at the edge ending phase_2f=1
// BEHAVIOUR
//  Reset state (async assert, sync release)
//   - All outputs are 0; phase_2f = 0; sel = 0.
//   - Assembly register, pending pair and flush counter are all cleared.
//  Phase
//   - phase_2f toggles every cycle after reset release; the first cycle after release is phase 0.
//   - A publish cycle is any cycle with phase_2f = 1.
//  Assembly
//   - valid_in with sel=0: store byte in a0; sel <- 1.
//   - valid_in with sel=1: pair {a0, data_in} is complete; sel <- 0.
//   - valid_in=0: no state change; sel is held, and bubbles are allowed anywhere.
//  Pending
//   - A pair completing in phase 0 goes to the pending register (pend_v <- 1).
//   - A pair completing in a publish cycle bypasses pending and publishes at that edge.
//   - Input is at most 1 byte/cycle, so at most 1 pair completes per window and pending never
//     overflows. If it ever would, that is an assertion failure in the bench.
//  Publish (registered at the edge closing each publish cycle)
//   - A pair is available (pend_v, or a bypass pair):
//     data_out0/1 <- pair; valid_out0 = valid_out1 = 1; pend_v <- 0.
//   - No pair available: valid_out0/1 <- 0, and data_out0/1 hold their previous values.
//  Timing
//   - Outputs change only at publish edges, so every value is stable for 2 cycles.
//   - Latency from the second byte of a pair to the outputs: 1 or 2 clk_4f edges, depending on phase.
//   - A full-rate input (valid_in=1 every cycle) gives valid_out0/1 = 1 continuously, with no loss.
//  Reset mid-operation
//   - A partial byte (a0) and any pending pair are discarded.
//   - Output valids drop to 0 immediately (async).
// CONFIGURATION
//  PARTIAL_FLUSH_EN defined
//   - A 0..FLUSH_TIMEOUT counter runs while sel=1 and valid_in=0. It clears on any valid_in and on sel=0.
//   - When the counter reaches FLUSH_TIMEOUT, the partial pair {a0, 0} becomes pending with a lane-1-invalid flag; sel <- 0.
//   - At its publish edge: valid_out0=1, valid_out1=0, data_out1=0.
//   - A valid_in in the same cycle as the timeout takes priority: the pair completes normally and no flush occurs.
//  PARTIAL_FLUSH_EN undefined
//   - No counter is built. A stranded lane-0 byte waits indefinitely for its partner.
//   - valid_out0 always equals valid_out1.
// TESTING
//  1. Assert reset_L=0 mid-stream.
//     -> All outputs read 0 immediately. After release, phase_2f starts at 0 and sel=0.
//  2. Input 0x11,0x22,0x33,0x44 on 4 consecutive cycles, starting in phase 0.
//     -> (0x11,0x22) then (0x33,0x44) appear with both valids =1; each value is stable for 2 cycles.
//  3. Same bytes, first byte in phase 1.
//     -> The same pairs appear one cycle later. No byte is lost, duplicated or lane-swapped.
//  4. Input 0xA0, 3 idle cycles, 0xA1.
//     -> Outputs (0xA0,0xA1) with both valids; valid_out=0 in every window with no pair.
//  5. With PARTIAL_FLUSH_EN: input 0x5A, then idle 4+ cycles.
//     -> Outputs data_out0=0x5A, valid_out0=1, valid_out1=0, data_out1=0.
//     -> The next byte, 0x6B, lands on lane 0.
//  6. Stream 64 random bytes at full rate into this block driving the L1 demux, and compare against a reference queue.
//     -> Byte order is preserved across all 4 L1 lanes.

Source files
------------

// File: rtl/demux1a2_stripe_l2_if.sv
// Byte-stream in / striped lane pair out bundle for demux1a2_stripe_l2.
// master: the byte source and lane consumer. slave: the striping stage.
interface demux1a2_stripe_l2_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic [DATA_W-1:0] data_out0;
   logic [DATA_W-1:0] data_out1;
   logic              valid_out0;
   logic              valid_out1;
   logic              phase_2f;

   modport master (
      output data_in, valid_in,
      input  data_out0, data_out1, valid_out0, valid_out1, phase_2f
   );

   modport slave (
      input  data_in, valid_in,
      output data_out0, data_out1, valid_out0, valid_out1, phase_2f
   );
endinterface

// File: rtl/demux1a2_stripe_l2.sv
// Byte striper ahead of the L1 2-to-4 demux. Even bytes go to lane 0, odd bytes
// to lane 1; each lane pair is published on a half-rate window so both lanes stay
// stable for two clk_4f cycles and can be sampled by the clk_2f stage.
// Optional feature macro: PARTIAL_FLUSH_EN (flushes a stranded lane-0 byte after
// FLUSH_TIMEOUT idle cycles, lane 1 marked invalid).
//
// Assembly state:
//   state     | meaning
//   ST_LANE0  | next byte is the even (lane 0) byte of a new pair
//   ST_LANE1  | lane 0 byte held in a0, waiting for its odd partner
module demux1a2_stripe_l2 #(
   parameter int DATA_W        = 8,
   parameter int FLUSH_TIMEOUT = 4
) (
   input  logic                 clk_4f,
   input  logic                 reset_L,
   demux1a2_stripe_l2_if.slave  bus
);

   typedef enum logic {
      ST_LANE0 = 1'b0,
      ST_LANE1 = 1'b1
   } sel_e;

   if (FLUSH_TIMEOUT < 1) begin : g_cfg_chk
      $error("FLUSH_TIMEOUT must be at least 1");
   end

   sel_e              sel_q, sel_d;
   logic              phase_q, phase_d;
   logic [DATA_W-1:0] a0_q, a0_d;
   logic              pend_v_q, pend_v_d;
   logic              pend_v1_q, pend_v1_d;
   logic [DATA_W-1:0] pend0_q, pend0_d;
   logic [DATA_W-1:0] pend1_q, pend1_d;
   logic [DATA_W-1:0] data_out0_q, data_out0_d;
   logic [DATA_W-1:0] data_out1_q, data_out1_d;
   logic              valid_out0_q, valid_out0_d;
   logic              valid_out1_q, valid_out1_d;

   logic              flush_hit;
   logic              pair_ev;
   logic              pair_v1;
   logic [DATA_W-1:0] pair0;
   logic [DATA_W-1:0] pair1;

`ifdef PARTIAL_FLUSH_EN
   localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);

   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             stranded;

   // Count idle cycles while a lane-0 byte waits; fire on the last one.
   always_comb begin
      stranded   = (sel_q == ST_LANE1) && !bus.valid_in;
      flush_hit  = stranded && (idle_cnt_q == CNT_W'(FLUSH_TIMEOUT - 1));
      idle_cnt_d = '0;
      if (stranded && !flush_hit) begin
         idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
   end

   // Idle counter register.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign flush_hit = 1'b0;
`endif

   // Assembly, pending hand-off and publish decisions for this cycle.
   always_comb begin
      sel_d        = sel_q;
      phase_d      = ~phase_q;
      a0_d         = a0_q;
      pend_v_d     = pend_v_q;
      pend_v1_d    = pend_v1_q;
      pend0_d      = pend0_q;
      pend1_d      = pend1_q;
      data_out0_d  = data_out0_q;
      data_out1_d  = data_out1_q;
      valid_out0_d = valid_out0_q;
      valid_out1_d = valid_out1_q;
      pair_ev      = 1'b0;
      pair_v1      = 1'b1;
      pair0        = a0_q;
      pair1        = bus.data_in;

      unique case (sel_q)
         ST_LANE0: begin
            if (bus.valid_in) begin
               a0_d  = bus.data_in;
               sel_d = ST_LANE1;
            end
         end
         ST_LANE1: begin
            if (bus.valid_in) begin
               pair_ev = 1'b1;
               sel_d   = ST_LANE0;
            end else if (flush_hit) begin
               pair_ev = 1'b1;
               pair1   = '0;
               pair_v1 = 1'b0;
               sel_d   = ST_LANE0;
            end
         end
         default: sel_d = ST_LANE0;
      endcase

      // A pair can never complete while pending is full: pending is only set
      // in phase 0 and that completion leaves sel at lane 0 for phase 1.
      if (phase_q) begin
         if (pend_v_q) begin
            data_out0_d  = pend0_q;
            data_out1_d  = pend1_q;
            valid_out0_d = 1'b1;
            valid_out1_d = pend_v1_q;
            pend_v_d     = 1'b0;
         end else if (pair_ev) begin
            data_out0_d  = pair0;
            data_out1_d  = pair1;
            valid_out0_d = 1'b1;
            valid_out1_d = pair_v1;
         end else begin
            valid_out0_d = 1'b0;
            valid_out1_d = 1'b0;
         end
      end else if (pair_ev) begin
         pend_v_d  = 1'b1;
         pend_v1_d = pair_v1;
         pend0_d   = pair0;
         pend1_d   = pair1;
      end
   end

   // State, pending and output registers.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         sel_q        <= ST_LANE0;
         phase_q      <= 1'b0;
         a0_q         <= '0;
         pend_v_q     <= 1'b0;
         pend_v1_q    <= 1'b0;
         pend0_q      <= '0;
         pend1_q      <= '0;
         data_out0_q  <= '0;
         data_out1_q  <= '0;
         valid_out0_q <= 1'b0;
         valid_out1_q <= 1'b0;
      end else begin
         sel_q        <= sel_d;
         phase_q      <= phase_d;
         a0_q         <= a0_d;
         pend_v_q     <= pend_v_d;
         pend_v1_q    <= pend_v1_d;
         pend0_q      <= pend0_d;
         pend1_q      <= pend1_d;
         data_out0_q  <= data_out0_d;
         data_out1_q  <= data_out1_d;
         valid_out0_q <= valid_out0_d;
         valid_out1_q <= valid_out1_d;
      end
   end

   assign bus.data_out0  = data_out0_q;
   assign bus.data_out1  = data_out1_q;
   assign bus.valid_out0 = valid_out0_q;
   assign bus.valid_out1 = valid_out1_q;
   assign bus.phase_2f   = phase_q;

endmodule
